// File: rtl/uart_pkg.sv
// Shared types and helpers for the 8N1 UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } state_e;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_tick.sv
// Oversample tick generator: one-clk pulse every CLK_DIV clocks, restartable via clr_i.
module uart_rx_tick #(
  parameter int CLK_DIV = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = !clr_i && (cnt_q == CW'(CLK_DIV - 1));
    if (clr_i || tick_o) cnt_d = '0;
    else                 cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled start validation, 3-sample majority vote per bit,
// byte handoff with dav/rd handshake plus framing and overrun flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_DIV = 12,
  parameter int OVS     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  input  logic                 rd,
  output logic [DATA_BITS-1:0] data,
  output logic                 dav,
  output logic                 fe,
  output logic                 oe,
  output logic                 busy
);

  localparam int SW = $clog2(OVS);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [SW-1:0] S_PRE = SW'(OVS/2 - 2);
  localparam logic [SW-1:0] S_CTR = SW'(OVS/2 - 1);
  localparam logic [SW-1:0] S_MID = SW'(OVS/2);
  localparam logic [SW-1:0] S_END = SW'(OVS - 1);

  state_e               state_q, state_d;
  logic [1:0]           sync_q;
  logic [SW-1:0]        scnt_q, scnt_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [2:0]           samp_q, samp_d;
  logic [DATA_BITS-1:0] sr_q, sr_d, data_q, data_d;
  logic                 dav_q, dav_d, fe_q, fe_d, oe_q, oe_d;
  logic                 rxs, tick, done, stop_maj;

  // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], rxd};
  end
  assign rxs = sync_q[1];

  uart_rx_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (state_q == IDLE),
    .tick_o (tick)
  );

  // NOTE: every signal gets a default first so the combinational block cannot infer latches.
  always_comb begin
    state_d  = state_q;
    scnt_d   = scnt_q;
    bcnt_d   = bcnt_q;
    samp_d   = samp_q;
    sr_d     = sr_q;
    data_d   = data_q;
    dav_d    = dav_q;
    fe_d     = fe_q;
    oe_d     = oe_q;
    done     = 1'b0;
    stop_maj = maj3(samp_q[0], samp_q[1], rxs);

    if (rd && dav_q) begin
      dav_d = 1'b0;
      fe_d  = 1'b0;
      oe_d  = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        scnt_d = '0;
        if (!rxs) state_d = START;
      end
      // The start bit runs its full length so DATA sample points land mid-bit.
      START: if (tick) begin
        if (scnt_q == S_CTR && rxs) begin
          state_d = IDLE;
        end else if (scnt_q == S_END) begin
          state_d = DATA;
          scnt_d  = '0;
          bcnt_d  = '0;
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end
      DATA: if (tick) begin
        if (scnt_q == S_PRE) samp_d[0] = rxs;
        if (scnt_q == S_CTR) samp_d[1] = rxs;
        if (scnt_q == S_MID) samp_d[2] = rxs;
        if (scnt_q == S_END) begin
          sr_d   = {maj3(samp_q[0], samp_q[1], samp_q[2]), sr_q[DATA_BITS-1:1]};
          scnt_d = '0;
          if (bcnt_q == BW'(DATA_BITS - 1)) state_d = STOP;
          else                              bcnt_d  = bcnt_q + 1'b1;
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end
      STOP: if (tick) begin
        if (scnt_q == S_PRE) samp_d[0] = rxs;
        if (scnt_q == S_CTR) samp_d[1] = rxs;
        if (scnt_q == S_MID) begin
          done    = 1'b1;
          scnt_d  = '0;
          state_d = (!stop_maj && !rxs) ? BRK : IDLE;
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end
      BRK: if (rxs) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A completing frame wins over a read for dav/fe; without room it is dropped.
    if (done) begin
      if (!dav_q || rd) begin
        data_d = sr_q;
        dav_d  = 1'b1;
        fe_d   = !stop_maj;
      end else begin
        oe_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      scnt_q  <= '0;
      bcnt_q  <= '0;
      samp_q  <= '0;
      sr_q    <= '0;
      data_q  <= '0;
      dav_q   <= 1'b0;
      fe_q    <= 1'b0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      bcnt_q  <= bcnt_d;
      samp_q  <= samp_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      dav_q   <= dav_d;
      fe_q    <= fe_d;
      oe_q    <= oe_d;
    end
  end

  assign data = data_q;
  assign dav  = dav_q;
  assign fe   = fe_q;
  assign oe   = oe_q;
  assign busy = (state_q != IDLE);

endmodule
